// File: rtl/imem_loader.sv
// Byte-stream to 32-bit instruction-memory loader: packs big-endian bytes into words,
// writes one word per cycle and flags partial/overflow sessions. Macro: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              byte_last,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_partial,
  output logic              err_overflow,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_idx;
  logic [23:0]         r_asm;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_last_seen;
  logic [ADDR_W:0]     r_word_count;
  logic                r_err_partial;
  logic                r_err_overflow;

  logic                w_accept;
  logic                w_word_end;
  logic                w_start_sess;
  logic                w_at_top;
  logic [31:0]         w_insert;

  assign w_accept   = (r_state == S_LOAD) && byte_valid;
  assign w_word_end = (r_idx == 2'd3) || byte_last;
  assign w_at_top   = (r_addr == {ADDR_W{1'b1}});

  // Inserting a byte also clears the lower lanes, so a short final word is zero-padded.
  always_comb begin
    w_insert = 32'h0;
    case (r_idx)
      2'd0:    w_insert = {byte_data, 24'h0};
      2'd1:    w_insert = {r_asm[23:16], byte_data, 16'h0};
      2'd2:    w_insert = {r_asm[23:8], byte_data, 8'h0};
      default: w_insert = {r_asm, byte_data};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    byte_ready   = 1'b0;
    mem_we       = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    w_start_sess = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next       = S_LOAD;
          w_start_sess = 1'b1;
        end
      end
      S_LOAD: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (w_accept && w_word_end) w_next = S_WRITE;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
        if (r_last_seen || w_at_top) w_next = S_DONE;
        else                         w_next = S_LOAD;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          w_next       = S_LOAD;
          w_start_sess = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx          <= 2'd0;
      r_asm          <= 24'h0;
      r_addr         <= '0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= 32'h0;
      r_last_seen    <= 1'b0;
      r_word_count   <= '0;
      r_err_partial  <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      if (w_start_sess) begin
        r_idx          <= 2'd0;
        r_asm          <= 24'h0;
        r_addr         <= '0;
        r_last_seen    <= 1'b0;
        r_word_count   <= '0;
        r_err_partial  <= 1'b0;
        r_err_overflow <= 1'b0;
      end
      if (w_accept) begin
        r_asm <= w_insert[31:8];
        r_idx <= r_idx + 2'd1;
        if (w_word_end) begin
          r_mem_wdata <= w_insert;
          r_mem_addr  <= r_addr;
          r_last_seen <= byte_last;
          r_idx       <= 2'd0;
          if (byte_last && (r_idx != 2'd3)) r_err_partial <= 1'b1;
        end
      end
      // The address saturates at the top word; the session ends there instead of wrapping.
      if (r_state == S_WRITE) begin
        r_word_count <= r_word_count + {{ADDR_W{1'b0}}, 1'b1};
        if (!w_at_top) r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (!r_last_seen && w_at_top) r_err_overflow <= 1'b1;
      end
    end
  end

  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign word_count   = r_word_count;
  assign err_partial  = r_err_partial;
  assign err_overflow = r_err_overflow;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge clk) begin
    if (!rst_n)                    r_checksum <= 32'h0;
    else if (w_start_sess)         r_checksum <= 32'h0;
    else if (r_state == S_WRITE)   r_checksum <= r_checksum ^ r_mem_wdata;
  end

  assign checksum = r_checksum;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the instruction-memory word-address width (depth 2^ADDR_W = 256 words).
REQ-002 SHALL have port clk  input  1  the single clock; all logic samples on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-004 SHALL have port start  input  1  begin or restart a load session; level sampled each cycle.
REQ-005 SHALL have port byte_valid  input  1  byte_data and byte_last are valid.
REQ-006 SHALL have port byte_data  input  8  program byte stream, big-endian within each word.
REQ-007 SHALL have port byte_last  input  1  the current byte is the final program byte.
REQ-008 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 SHALL have port mem_addr  output  ADDR_W  word address for the write.
REQ-011 SHALL have port mem_wdata  output  32  assembled instruction word.
REQ-012 SHALL have port busy  output  1  high in LOAD or WRITE.
REQ-013 SHALL have port done  output  1  high in DONE, held until the next start.
REQ-014 SHALL have port word_count  output  ADDR_W+1  number of words written in the current session.
REQ-015 SHALL have port err_partial  output  1  sticky; byte_last arrived on a non-word boundary.
REQ-016 SHALL have port err_overflow  output  1  sticky; memory filled before byte_last arrived.
REQ-017 SHALL have port checksum  output  32  running XOR of all written words.

Function
REQ-018 SHALL implement the FSM states IDLE, LOAD, WRITE and DONE.
REQ-019 IDLE/DONE: byte_ready=0; start=1 -> LOAD next cycle, clearing address, byte index, word_count, err_partial, err_overflow, checksum and done.
REQ-020 LOAD: byte_ready=1; a byte is accepted only when byte_valid && byte_ready; byte index 0..3 fills mem_wdata[31:24], [23:16], [15:8] and [7:0] respectively.
REQ-021 LOAD -> WRITE in the cycle after acceptance of byte index 3, or after acceptance of any byte with byte_last=1.
REQ-022 On byte_last at index 0..2, remaining lower bytes SHALL be zero-padded and err_partial set to 1.
REQ-023 WRITE lasts exactly one cycle: mem_we=1, byte_ready=0, mem_addr=current address, mem_wdata stable; latency from accepted 4th byte to mem_we is 1 cycle.
REQ-024 On leaving WRITE: address+1, word_count+1, checksum ^= mem_wdata.
REQ-025 WRITE -> DONE if byte_last was seen for this word; else if address was 2^ADDR_W-1 -> DONE with err_overflow=1; else -> LOAD.
REQ-026 start SHALL be ignored in LOAD and WRITE.
REQ-027 mem_we SHALL be 0 in all states except WRITE; mem_addr/mem_wdata hold their last values otherwise.
REQ-028 Address SHALL never wrap; no write to address 0 occurs after 2^ADDR_W-1 in one session.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force state IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, word_count=0, err_partial=0, err_overflow=0 and checksum=0.
REQ-030 Reset mid-LOAD or mid-WRITE SHALL discard the partial word with no write, and SHALL take priority over start and byte_valid.

Configuration
REQ-031 Macro IMEM_LOADER_CHECKSUM_EN defined: checksum operates per REQ-024.
REQ-032 Macro IMEM_LOADER_CHECKSUM_EN undefined: checksum SHALL be constant 0, no XOR logic is present, and all other behaviour is identical.

Verification
REQ-033 Bench SHALL cover: reset, start, then bytes 8C,01,00,20 with last on the 4th byte -> one mem_we at addr 0 with wdata 8C010020, word_count=1, done=1, errors 0.
REQ-034 Bench SHALL cover: 12 bytes streamed with byte_valid gaps -> 3 writes at addr 0,1,2, each 1 cycle after its 4th byte, and byte_ready=0 during each WRITE.
REQ-035 Bench SHALL cover: 6 bytes AA,BB,CC,DD,11,22 with last on 22 -> writes AABBCCDD then 11220000, err_partial=1, word_count=2.
REQ-036 Bench SHALL cover: 1028 bytes with no last -> 256 writes at addr 0..255, err_overflow=1, DONE, no write to addr 0 after 255.
REQ-037 Bench SHALL cover: rst_n=0 after 2 bytes of word 1 -> no mem_we, all outputs 0; new session writes its first word to addr 0.
REQ-038 Bench SHALL cover: with IMEM_LOADER_CHECKSUM_EN, words 00000001 and 00000003 give checksum=00000002; without the macro, checksum=0.
